mult_ctrl: RTL and testbench
============================

Name: mult_ctrl

Overview:
Sequencer for the 4-bit shift-add multiplier datapath. It drives the carry register G, accumulator A, operand register B and multiplier register Q. It issues Clear, Load and Shift strobes to those registers and samples the LSB of Q to decide add-or-skip for each bit. A Start/Busy/Done handshake connects it to the top-level control logic and the display.

Parameters:
WIDTH, 4, operand width in bits; equals the number of add/shift iterations.
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
Mult_Ctrl_Clock  input  1  rising-edge clock for all state.
Mult_Ctrl_Reset_n  input  1  synchronous, active-low reset.
Mult_Ctrl_Start  input  1  level request; sampled only in IDLE.
Mult_Ctrl_Q0  input  1  LSB of multiplier register Q; sampled only in TEST.
Mult_Ctrl_Clear  output  1  clears G and A.
Mult_Ctrl_Load_Op  output  1  loads B and Q from the operand switches.
Mult_Ctrl_Load  output  1  loads adder sum into A and carry into G.
Mult_Ctrl_Shift  output  1  right-shifts the G:A:Q chain and clears G.
Mult_Ctrl_Busy  output  1  high while a multiply is in progress.
Mult_Ctrl_Done  output  1  one-cycle pulse: product valid in A:Q.

Behaviour:
- Reset: on any rising edge with Reset_n=0:
  - state goes to IDLE and the counter goes to 0;
  - all outputs are 0 from the next cycle;
  - reset overrides everything, including mid-operation.
- Outputs are Moore-decoded from the state register only. There is no combinational path from Start or Q0 to any output.
- States and transitions:
  - IDLE: all outputs 0. Start=1 -> INIT; otherwise stay.
  - INIT: Clear=1, Load_Op=1, Busy=1; counter <= WIDTH. -> TEST.
  - TEST: Busy=1. Q0=1 -> ADD; Q0=0 -> SHIFT.
  - ADD: Load=1, Busy=1. -> SHIFT.
  - SHIFT: Shift=1, Busy=1; counter <= counter-1. If counter==1 before the decrement -> DONE, else -> TEST.
  - DONE: Done=1, Busy=0. -> IDLE unconditionally.
  - Any unused encoding -> IDLE on the next edge, with all outputs 0 in that cycle.
- Exactly one of Clear/Load/Shift is high in any cycle. Load_Op is high only together with Clear, in INIT.
- Start is ignored in every state other than IDLE; it is never queued.
- If Start is still high when DONE exits: exactly one IDLE cycle, then INIT.
- Latency from the edge that samples Start in IDLE:
  - Done is high in cycle 2 + 2*WIDTH + (number of 1 bits in Q);
  - cycle 1 is INIT.
- The counter never wraps. It leaves SHIFT at 0 only on the transition to DONE.
- Q0 changes only after a Shift edge, so Q0 is stable while in TEST.

Decomposition:
- Shared include mult_defs.vh holds:
  - state encoding localparams: IDLE=3'd0, INIT=1, TEST=2, ADD=3, SHIFT=4, DONE=5;
  - the WIDTH default.
- The datapath register modules use the same include for WIDTH.
- No sub-module: the counter and the FSM are small enough to stay inline in one module.

Test Plan:
1. Reset_n=0 for 2 cycles with Start=1 -> all outputs 0 throughout; after release, INIT appears on the cycle after the first sampled Start.
2. Start pulse with Q0 held 0 -> Clear and Load_Op high for 1 cycle; Load never high; 4 Shift pulses spaced 2 cycles apart; Done high in cycle 10; Busy high in cycles 1-9.
3. Start with Q0 held 1 -> 4 Load pulses, each immediately followed by a Shift; Done in cycle 14; never two strobes in the same cycle.
4. Bench behavioural G/A/B/Q model, B=4'b1011, Q=4'b1101 -> 3 Load pulses; A:Q=8'b1000_1111 (143) at the Done cycle; Done in cycle 13.
5. Reset_n=0 pulsed during the 2nd SHIFT -> next cycle state IDLE with all outputs 0; a new Start with B=4'd15, Q=4'd15 -> A:Q=8'd225.
6. Start held high across 2 operations; Start toggled while Busy -> no effect on sequencing; exactly 1 IDLE cycle between Done and the next Clear/Load_Op.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
// State encoding and default datapath width.
package mult_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic clear;
        logic load_op;
        logic load;
        logic shift;
        logic busy;
        logic done;
    } strobe_t;

endpackage

// File: rtl/mult_ctrl_if.sv
// Handshake and strobe bundle between the sequencer and the
// G/A/B/Q datapath plus top-level control.
interface mult_ctrl_if;

    logic Mult_Ctrl_Start;
    logic Mult_Ctrl_Q0;
    logic Mult_Ctrl_Clear;
    logic Mult_Ctrl_Load_Op;
    logic Mult_Ctrl_Load;
    logic Mult_Ctrl_Shift;
    logic Mult_Ctrl_Busy;
    logic Mult_Ctrl_Done;

    modport master (
        input  Mult_Ctrl_Start,
        input  Mult_Ctrl_Q0,
        output Mult_Ctrl_Clear,
        output Mult_Ctrl_Load_Op,
        output Mult_Ctrl_Load,
        output Mult_Ctrl_Shift,
        output Mult_Ctrl_Busy,
        output Mult_Ctrl_Done
    );

    modport slave (
        output Mult_Ctrl_Start,
        output Mult_Ctrl_Q0,
        input  Mult_Ctrl_Clear,
        input  Mult_Ctrl_Load_Op,
        input  Mult_Ctrl_Load,
        input  Mult_Ctrl_Shift,
        input  Mult_Ctrl_Busy,
        input  Mult_Ctrl_Done
    );

endinterface

// File: rtl/mult_ctrl.sv
// Moore sequencer for the 4-bit shift-add multiplier: one add/skip
// decision and one shift per operand bit, Start/Busy/Done handshake.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         Mult_Ctrl_Clock,
    input  logic         Mult_Ctrl_Reset_n,
    mult_ctrl_if.master  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    strobe_t            st;

    always_ff @(posedge Mult_Ctrl_Clock) begin
        if (!Mult_Ctrl_Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        st      = '0;
        unique case (state_q)
            S_IDLE: begin
                state_d = bus.Mult_Ctrl_Start ? S_INIT : S_IDLE;
            end
            S_INIT: begin
                st.clear   = 1'b1;
                st.load_op = 1'b1;
                st.busy    = 1'b1;
                cnt_d      = CNT_W'(WIDTH);
                state_d    = S_TEST;
            end
            S_TEST: begin
                st.busy = 1'b1;
                state_d = bus.Mult_Ctrl_Q0 ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                st.load = 1'b1;
                st.busy = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                st.shift = 1'b1;
                st.busy  = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                // last bit processed: counter lands on 0 only here
                state_d  = (cnt_q == CNT_W'(1)) ? S_DONE : S_TEST;
            end
            S_DONE: begin
                st.done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.Mult_Ctrl_Clear   = st.clear;
    assign bus.Mult_Ctrl_Load_Op = st.load_op;
    assign bus.Mult_Ctrl_Load    = st.load;
    assign bus.Mult_Ctrl_Shift   = st.shift;
    assign bus.Mult_Ctrl_Busy    = st.busy;
    assign bus.Mult_Ctrl_Done    = st.done;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: G/A/B/Q register harness driving Q0, products
// and timing compared against arithmetic expectations.
module tb_mult_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mult_ctrl_if bus();

    mult_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .Mult_Ctrl_Clock   (clk),
        .Mult_Ctrl_Reset_n (rst_n),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] sw_b = '0;
    logic [3:0] sw_q = '0;
    logic [3:0] reg_b = '0;
    logic [3:0] reg_a = '0;
    logic [3:0] reg_q = '0;
    logic       reg_g = 1'b0;

    assign bus.Mult_Ctrl_Q0 = reg_q[0];

    always @(posedge clk) begin
        if (bus.Mult_Ctrl_Load_Op) begin
            reg_b <= sw_b;
            reg_q <= sw_q;
        end
        if (bus.Mult_Ctrl_Clear) begin
            reg_g <= 1'b0;
            reg_a <= '0;
        end
        if (bus.Mult_Ctrl_Load)
            {reg_g, reg_a} <= {1'b0, reg_a} + {1'b0, reg_b};
        if (bus.Mult_Ctrl_Shift)
            {reg_g, reg_a, reg_q} <= {1'b0, reg_g, reg_a, reg_q[3:1]};
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return {26'b0, bus.Mult_Ctrl_Clear, bus.Mult_Ctrl_Load_Op,
                bus.Mult_Ctrl_Load, bus.Mult_Ctrl_Shift,
                bus.Mult_Ctrl_Busy, bus.Mult_Ctrl_Done};
    endfunction

    // Call with the next negedge falling in an IDLE cycle.
    task automatic run_op(input logic [3:0] b, input logic [3:0] q,
                          input bit keep, input bit tog,
                          input int exp_prod, input int exp_done,
                          input string tag);
        int clr_cyc = -1;
        int done_cyc = -1;
        int loads = 0;
        int shifts = 0;
        int viol = 0;
        int busy_err = 0;
        int prod = -1;
        int n;
        bit prev_load = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, outs(), 0);
        sw_b = b;
        sw_q = q;
        bus.Mult_Ctrl_Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Mult_Ctrl_Start = keep;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            n = int'(bus.Mult_Ctrl_Clear) + int'(bus.Mult_Ctrl_Load)
              + int'(bus.Mult_Ctrl_Shift);
            if (n > 1) viol++;
            if (bus.Mult_Ctrl_Load_Op != bus.Mult_Ctrl_Clear) viol++;
            if (prev_load && !bus.Mult_Ctrl_Shift) viol++;
            prev_load = bus.Mult_Ctrl_Load;
            if (bus.Mult_Ctrl_Clear && clr_cyc < 0) clr_cyc = cyc;
            loads += int'(bus.Mult_Ctrl_Load);
            shifts += int'(bus.Mult_Ctrl_Shift);
            if (bus.Mult_Ctrl_Busy != (cyc < exp_done)) busy_err++;
            if (bus.Mult_Ctrl_Done) begin
                done_cyc = cyc;
                prod = int'({reg_a, reg_q});
            end
            if (tog) bus.Mult_Ctrl_Start = 1'($urandom_range(0, 1));
        end
        bus.Mult_Ctrl_Start = keep;
        check({tag, "_clear_cyc"}, clr_cyc, 1);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_loads"}, loads, $countones(q));
        check({tag, "_shifts"}, shifts, W);
        check({tag, "_product"}, prod, exp_prod);
        check({tag, "_strobe_viol"}, viol, 0);
        check({tag, "_busy_err"}, busy_err, 0);
    endtask

    typedef struct {
        logic [3:0] b;
        logic [3:0] q;
        int         prod;
        int         done;
        string      name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [3:0] rb, rq;
        int nsh;

        vecs[0] = '{4'd5,  4'd0,  0,   10, "q_zero"};
        vecs[1] = '{4'd3,  4'd15, 45,  14, "q_ones"};
        vecs[2] = '{4'd11, 4'd13, 143, 13, "b11_q13"};
        vecs[3] = '{4'd15, 4'd15, 225, 14, "max"};
        vecs[4] = '{4'd9,  4'd6,  54,  12, "b9_q6"};
        vecs[5] = '{4'd0,  4'd10, 0,   12, "b_zero"};

        bus.Mult_Ctrl_Start = 1'b1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_outs", outs(), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_init", outs(), 6'b110010);
        bus.Mult_Ctrl_Start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_again", outs(), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].b, vecs[i].q, 1'b0, 1'b0,
                   vecs[i].prod, vecs[i].done, vecs[i].name);

        // reset asserted while the second shift is in flight
        @(negedge clk);
        sw_b = 4'd15;
        sw_q = 4'd15;
        bus.Mult_Ctrl_Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Mult_Ctrl_Start = 1'b0;
        nsh = 0;
        for (int i = 0; i < 30 && nsh < 2; i++) begin
            @(negedge clk);
            if (bus.Mult_Ctrl_Shift) nsh++;
        end
        check("midop_shift2_seen", nsh, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midop_rst_outs", outs(), 0);
        rst_n = 1'b1;
        run_op(4'd15, 4'd15, 1'b0, 1'b0, 225, 14, "after_rst");

        run_op(4'd7,  4'd9, 1'b1, 1'b1, 63, 12, "b2b0");
        run_op(4'd12, 4'd5, 1'b1, 1'b0, 60, 12, "b2b1");
        run_op(4'd6,  4'd3, 1'b0, 1'b1, 18, 12, "b2b2");

        repeat (20) begin
            rb = 4'($urandom);
            rq = 4'($urandom);
            run_op(rb, rq, 1'b0, 1'($urandom_range(0, 1)),
                   int'(rb) * int'(rq), 2 + 2 * W + $countones(rq), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
